mul_sequencer: RTL and testbench

Iterative shift-add multiplier and controller for the EX stage: it executes the MUL operation (ALU control code 3'b101) over multiple cycles instead of in one combinational step. It accepts operands when the decoded ALU control selects multiply and stalls the pipeline while it runs. It then presents the low WIDTH bits of the product for one cycle. All other ALU control codes pass through untouched; this block never asserts stall for them.

---
 rtl/mul_sequencer.sv | 109 ++++++++++
 tb/tb_mul_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage (ALU control MUL), low WIDTH bits of the product.
// Latency: accept cycle T, k RUN cycles (WIDTH, or fewer with EARLY_EXIT), done_o pulses in T+k+1.
// Backpressure: stall_o holds the front of the pipeline from the accept cycle through the last RUN cycle.
module mul_sequencer #(
   parameter int         WIDTH      = 32,
   parameter int         EARLY_EXIT = 1,
   parameter logic [2:0] MUL_CTL    = 3'b101
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       ctl_i,
   input  logic [WIDTH-1:0] rs1_data_i,
   input  logic [WIDTH-1:0] rs2_data_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last_step;
   logic [WIDTH-1:0] acc_nxt;

   // A new multiply is taken only from IDLE; a flush in the same cycle kills it before it starts.
   assign accept    = (state == IDLE) && start_i && (ctl_i == MUL_CTL) && !flush_i;

   // Stall is combinational so the accepting instruction is held in EX in its own cycle.
   assign stall_o   = (state == RUN) || accept;

   // Partial-product add; wrap-around keeps only the low half, valid for signed and unsigned.
   assign acc_nxt   = mplier[0] ? acc + mcand : acc;

   // Last iteration: full count reached, or no multiplier bits remain after this shift.
   assign last_step = (cnt == LAST_CNT) ||
                      ((EARLY_EXIT != 0) && (mplier[WIDTH-1:1] == '0));

   // Controller FSM with datapath registers and registered busy/done decodes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         result_o <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (accept) begin
                  acc    <= '0;
                  mcand  <= rs1_data_i;
                  mplier <= rs2_data_i;
                  cnt    <= '0;
                  state  <= RUN;
                  busy_o <= 1'b1;
               end
            end
            RUN: begin
               if (flush_i) begin
                  // Killed instruction: leave result_o untouched and skip DONE.
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CW'(1);
                  if (last_step) begin
                     state    <= DONE;
                     result_o <= acc_nxt;
                     done_o   <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: two instances (EARLY_EXIT=0 and 1) share one stimulus stream.
// A cycle-window reference model checks stall/busy each cycle and queues expected products.
// Monitors pop the queues on done_o and check result value, completion cycle and hold behaviour.
module tb_mul_sequencer;

   localparam logic [2:0] MUL = 3'b101;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  ctl = 3'b000;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        flush = 1'b0;

   logic        stall [2];
   logic        busy  [2];
   logic        done  [2];
   logic [31:0] res   [2];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   exp_t q0[$];
   exp_t q1[$];

   // reference model state: one outstanding operation window per instance
   bit          m_active [2];
   int          m_t      [2];
   int          m_k      [2];
   logic [31:0] m_res    [2];
   logic [31:0] last_res [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_sequencer #(.WIDTH(32), .EARLY_EXIT(0), .MUL_CTL(MUL)) u_full (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ctl_i(ctl),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .flush_i(flush),
      .stall_o(stall[0]), .busy_o(busy[0]), .done_o(done[0]), .result_o(res[0])
   );

   mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1), .MUL_CTL(MUL)) u_early (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ctl_i(ctl),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .flush_i(flush),
      .stall_o(stall[1]), .busy_o(busy[1]), .done_o(done[1]), .result_o(res[1])
   );

   task automatic check(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cycle %0d: got 0x%08h expected 0x%08h",
                  name, inst, cyc, act, exp);
      end
   endtask

   // Run length from the operand alone: full width, or highest set multiplier bit + 1 (min 1).
   function automatic int calc_k(input logic [31:0] b, input bit early);
      int k;
      if (!early) return 32;
      k = 1;
      for (int j = 0; j < 32; j++)
         if (b[j]) k = j + 1;
      return k;
   endfunction

   // Reference model: per-cycle stall/busy expectations, queue the product once it is committed.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit in_run;
         bit in_done;
         bit acc_e;
         if (rst) begin
            m_active[i] = 1'b0;
            if (i == 0) q0.delete(); else q1.delete();
         end else begin
            in_run  = m_active[i] && (cyc > m_t[i]) && (cyc <= m_t[i] + m_k[i]);
            in_done = m_active[i] && (cyc == m_t[i] + m_k[i] + 1);
            acc_e   = !in_run && !in_done && start && (ctl == MUL) && !flush;
            check("stall", i, {31'd0, stall[i]}, {31'd0, in_run || acc_e});
            check("busy",  i, {31'd0, busy[i]},  {31'd0, in_run || in_done});
            if (in_run && flush) begin
               m_active[i] = 1'b0;
            end else if (in_run && (cyc == m_t[i] + m_k[i])) begin
               exp_t e;
               e.res = m_res[i];
               e.cyc = cyc + 1;
               if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (in_done) m_active[i] = 1'b0;
            if (acc_e) begin
               m_active[i] = 1'b1;
               m_t[i]      = cyc;
               m_k[i]      = calc_k(rs2, i == 1);
               m_res[i]    = rs1 * rs2;
            end
         end
      end
   end

   // Monitor: pop on done_o, check value and cycle; otherwise result_o must hold.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit   have;
         exp_t e;
         if (rst) begin
            last_res[i] = '0;
         end else begin
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (have) e = (i == 0) ? q0[0] : q1[0];
            if (done[i]) begin
               if (!have) begin
                  check("unexpected_done", i, 32'd1, 32'd0);
               end else begin
                  if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                  check("result", i, res[i], e.res);
                  check("done_cycle", i, cyc, e.cyc);
                  last_res[i] = e.res;
               end
            end else begin
               check("result_hold", i, res[i], last_res[i]);
               if (have && e.cyc <= cyc) begin
                  check("missing_done", i, 32'd0, 32'd1);
                  if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0;
      ctl   = 3'b000;
      flush = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 45; n++) begin
         step();
         if (!busy[0] && !busy[1]) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 0, {31'd0, ok}, 32'd1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name);
      step();
      start = 1'b1;
      ctl   = MUL;
      rs1   = a;
      rs2   = b;
      step();
      idle_inputs();
      rs1 = $urandom;
      rs2 = $urandom;
      wait_idle(name);
      step();
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("reset_stall",  i, {31'd0, stall[i]}, 32'd0);
         check("reset_busy",   i, {31'd0, busy[i]},  32'd0);
         check("reset_done",   i, {31'd0, done[i]},  32'd0);
         check("reset_result", i, res[i],            32'd0);
      end

      run_op(32'd7,        32'd6,        "idle_7x6");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "idle_wrap");
      run_op(32'h10,       32'd5,        "idle_10x5");
      run_op(32'h1234,     32'd0,        "idle_x0");
      run_op(32'd1,        32'h8000_0000, "idle_topbit");

      // flush in the 10th RUN cycle while start_i and ctl_i keep changing
      step();
      start = 1'b1;
      ctl   = MUL;
      rs1   = 32'd3;
      rs2   = 32'h8000_0001;
      for (int j = 1; j < 10; j++) begin
         step();
         start = 1'b1;
         ctl   = 3'($urandom);
         rs1   = $urandom;
         rs2   = $urandom;
      end
      step();
      flush = 1'b1;
      step();
      idle_inputs();
      for (int i = 0; i < 2; i++)
         check("flush_busy", i, {31'd0, busy[i]}, 32'd0);
      step();

      // non-multiply control code, then multiply with a same-cycle flush
      start = 1'b1;
      ctl   = 3'b011;
      step();
      for (int i = 0; i < 2; i++)
         check("add_busy", i, {31'd0, busy[i]}, 32'd0);
      ctl   = MUL;
      flush = 1'b1;
      step();
      idle_inputs();
      for (int i = 0; i < 2; i++)
         check("flush_accept_busy", i, {31'd0, busy[i]}, 32'd0);

      // reset held two cycles in the middle of a run
      step();
      start = 1'b1;
      ctl   = MUL;
      rs1   = 32'd9;
      rs2   = 32'hC000_0003;
      step();
      idle_inputs();
      for (int j = 0; j < 5; j++) step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("midrst_stall",  i, {31'd0, stall[i]}, 32'd0);
         check("midrst_busy",   i, {31'd0, busy[i]},  32'd0);
         check("midrst_done",   i, {31'd0, done[i]},  32'd0);
         check("midrst_result", i, res[i],            32'd0);
      end
      for (int j = 0; j < 40; j++) step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         start = 1'($urandom_range(0, 1));
         ctl   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : MUL;
         flush = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 599) == 0);
         rs1   = $urandom;
         rs2   = $urandom >> $urandom_range(0, 31);
      end
      step();
      idle_inputs();
      rst = 1'b0;
      for (int j = 0; j < 40; j++) step();
      check("q_full_empty",  0, q0.size(), 32'd0);
      check("q_early_empty", 1, q1.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
